// File: rtl/hazard3_trigger_unit.sv
// Debug trigger unit: N mcontrol-style address-match triggers with pairwise
// chaining, sticky hit bits, CSR access through tselect/tdata1/tdata2/tinfo,
// and a registered break request held until the core acknowledges it.
// The tdata1 layout is the 32-bit one; W_DATA must be at least 32.
module hazard3_trigger_unit #(
  parameter int N_TRIGGERS = 4,
  parameter int W_DATA     = 32,
  parameter int W_ADDR     = 32,
  parameter int CHAIN_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       cfg_addr,
  input  logic              cfg_wen,
  input  logic [W_DATA-1:0] cfg_wdata,
  output logic [W_DATA-1:0] cfg_rdata,
  input  logic              trig_m_en,
  input  logic              m_mode,
  input  logic              d_mode,
  input  logic              pc_vld,
  input  logic [W_ADDR-1:0] pc,
  input  logic              dmem_vld,
  input  logic              dmem_write,
  input  logic [W_ADDR-1:0] dmem_addr,
  output logic              break_req,
  output logic              break_d_mode,
  output logic [3:0]        break_idx,
  input  logic              break_ack
);

  localparam int W_TS = (N_TRIGGERS > 1) ? $clog2(N_TRIGGERS) : 1;

  localparam logic [11:0] CSR_TSELECT = 12'h7a0;
  localparam logic [11:0] CSR_TDATA1  = 12'h7a1;
  localparam logic [11:0] CSR_TDATA2  = 12'h7a2;
  localparam logic [11:0] CSR_TINFO   = 12'h7a4;

  typedef enum logic [1:0] {
    MATCH_EQ    = 2'd0,
    MATCH_NAPOT = 2'd1,
    MATCH_GE    = 2'd2,
    MATCH_LT    = 2'd3
  } match_t;

  typedef struct packed {
    logic   dmode;
    logic   action;
    logic   chain;
    match_t match;
    logic   m;
    logic   u;
    logic   execute;
    logic   store;
    logic   load;
    logic   hit;
  } trig_cfg_t;

  logic [W_TS-1:0]   tselect;
  trig_cfg_t         cfg_q    [N_TRIGGERS];
  logic [W_DATA-1:0] tdata2_q [N_TRIGGERS];

  logic [N_TRIGGERS-1:0] raw;
  logic [N_TRIGGERS-1:0] grp_all;
  logic [N_TRIGGERS-1:0] fire;
  logic [N_TRIGGERS-1:0] in_fire;
  logic                  any_fire;
  logic                  sel_d_mode;
  logic [3:0]            sel_idx;
  logic                  load_break;

  logic                  sel_valid;
  trig_cfg_t             rd_cfg;
  logic [W_DATA-1:0]     rd_tdata2;
  logic [31:0]           tdata1_word;

  logic wr_tselect;
  logic wr_tdata1;
  logic wr_tdata2;

  // Address comparison for one trigger in its configured match mode.
  // For NAPOT, t2 ^ (t2 + 1) sets bits [k:0] where k is the count of
  // trailing ones, which are exactly the address bits to ignore.
  function automatic logic addr_match(input match_t mode,
                                      input logic [W_DATA-1:0] t2,
                                      input logic [W_ADDR-1:0] a);
    logic [W_DATA-1:0] v;
    logic [W_DATA-1:0] mask;
    v    = W_DATA'(a);
    mask = t2 ^ (t2 + W_DATA'(1));
    case (mode)
      MATCH_EQ:    return v == t2;
      MATCH_NAPOT: return (v & ~mask) == (t2 & ~mask);
      MATCH_GE:    return v >= t2;
      default:     return v < t2;
    endcase
  endfunction

  assign wr_tselect = cfg_wen && (cfg_addr == CSR_TSELECT);
  assign wr_tdata1  = cfg_wen && (cfg_addr == CSR_TDATA1);
  assign wr_tdata2  = cfg_wen && (cfg_addr == CSR_TDATA2);
  assign sel_valid  = 32'(tselect) < N_TRIGGERS;

  // Match, chain grouping, firing and break prioritisation.
  always_comb begin
    // NOTE: every variable assigned here gets a value up front so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    raw        = '0;
    grp_all    = '0;
    fire       = '0;
    in_fire    = '0;
    any_fire   = 1'b0;
    sel_d_mode = 1'b0;
    sel_idx    = 4'd0;

    for (int i = 0; i < N_TRIGGERS; i++) begin
      raw[i] = ((cfg_q[i].execute && pc_vld &&
                 addr_match(cfg_q[i].match, tdata2_q[i], pc)) ||
                (dmem_vld && (dmem_write ? cfg_q[i].store : cfg_q[i].load) &&
                 addr_match(cfg_q[i].match, tdata2_q[i], dmem_addr)))
               && !d_mode && (m_mode ? cfg_q[i].m : cfg_q[i].u);
    end

    // grp_all[i]: every trigger from the start of i's chain up to i matched.
    grp_all[0] = raw[0];
    for (int i = 1; i < N_TRIGGERS; i++) begin
      grp_all[i] = raw[i] && (!cfg_q[i-1].chain || grp_all[i-1]);
    end

    // Only the last member of a group (chain=0) can fire.
    for (int i = 0; i < N_TRIGGERS; i++) begin
      fire[i] = grp_all[i] && !cfg_q[i].chain &&
                (cfg_q[i].action ? cfg_q[i].dmode : trig_m_en);
    end

    // Spread a group's fire back over its members for hit-bit update.
    in_fire[N_TRIGGERS-1] = fire[N_TRIGGERS-1];
    for (int i = N_TRIGGERS - 2; i >= 0; i--) begin
      in_fire[i] = cfg_q[i].chain ? in_fire[i+1] : fire[i];
    end

    any_fire = |fire;

    // Lowest-index M-mode fire, then any D-mode fire overrides it.
    for (int i = N_TRIGGERS - 1; i >= 0; i--) begin
      if (fire[i] && !cfg_q[i].action) sel_idx = 4'(i);
    end
    for (int i = N_TRIGGERS - 1; i >= 0; i--) begin
      if (fire[i] && cfg_q[i].action) begin
        sel_idx    = 4'(i);
        sel_d_mode = 1'b1;
      end
    end
  end

  assign load_break = any_fire && (!break_req || break_ack);

  // Pending break register: loads on a fire when idle or being acked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      break_req    <= 1'b0;
      break_d_mode <= 1'b0;
      break_idx    <= 4'd0;
    end else if (load_break) begin
      // NOTE: state registers use non-blocking assignment so all flops
      // update together from the values present before the edge.
      break_req    <= 1'b1;
      break_d_mode <= sel_d_mode;
      break_idx    <= sel_idx;
    end else if (break_ack) begin
      break_req    <= 1'b0;
    end
  end

  // Trigger select register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tselect <= '0;
    end else if (wr_tselect) begin
      tselect <= cfg_wdata[W_TS-1:0];
    end
  end

  // Per-trigger configuration and sticky hit bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the trigger array is reset element by element because its
      // contents are architectural state that must start disarmed; this keeps
      // it in flops rather than a RAM macro.
      for (int i = 0; i < N_TRIGGERS; i++) begin
        cfg_q[i]    <= '0;
        tdata2_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_TRIGGERS; i++) begin
        // A D-mode-only trigger is locked against writes from outside D-mode.
        if ((32'(tselect) == i) && !(cfg_q[i].dmode && !d_mode)) begin
          if (wr_tdata1) begin
            if (d_mode) cfg_q[i].dmode <= cfg_wdata[27];
            cfg_q[i].action  <= cfg_wdata[12];
            cfg_q[i].chain   <= (CHAIN_EN != 0) && (i != N_TRIGGERS - 1) &&
                                cfg_wdata[11];
            cfg_q[i].match   <= (cfg_wdata[10:9] == 2'b00) ?
                                match_t'(cfg_wdata[8:7]) : MATCH_EQ;
            cfg_q[i].m       <= cfg_wdata[6];
            cfg_q[i].u       <= cfg_wdata[3];
            cfg_q[i].execute <= cfg_wdata[2];
            cfg_q[i].store   <= cfg_wdata[1];
            cfg_q[i].load    <= cfg_wdata[0];
            if (!cfg_wdata[20]) cfg_q[i].hit <= 1'b0;
          end
          if (wr_tdata2) tdata2_q[i] <= cfg_wdata;
        end
        // Later assignment: a hardware set beats a same-cycle software clear.
        if (load_break && in_fire[i]) cfg_q[i].hit <= 1'b1;
      end
    end
  end

  // CSR read mux for the currently selected trigger.
  always_comb begin
    rd_cfg    = '0;
    rd_tdata2 = '0;
    for (int i = 0; i < N_TRIGGERS; i++) begin
      if (32'(tselect) == i) begin
        rd_cfg    = cfg_q[i];
        rd_tdata2 = tdata2_q[i];
      end
    end

    tdata1_word = {4'h2, rd_cfg.dmode, 6'd31, rd_cfg.hit, 1'b0, 1'b0, 2'b00,
                   3'b000, rd_cfg.action, rd_cfg.chain, 2'b00, rd_cfg.match,
                   rd_cfg.m, 1'b0, 1'b0, rd_cfg.u, rd_cfg.execute,
                   rd_cfg.store, rd_cfg.load};

    case (cfg_addr)
      CSR_TSELECT: cfg_rdata = W_DATA'(tselect);
      CSR_TDATA1:  cfg_rdata = sel_valid ? W_DATA'(tdata1_word) : '0;
      CSR_TDATA2:  cfg_rdata = sel_valid ? rd_tdata2 : '0;
      CSR_TINFO:   cfg_rdata = sel_valid ? W_DATA'(4) : W_DATA'(1);
      default:     cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hazard3_trigger_unit.sv
// Self-checking bench for hazard3_trigger_unit. Directed stimulus pushes each
// expected break {d_mode, idx} into a queue; a monitor pops and compares
// whenever the DUT presents a newly loaded break request.
module tb_hazard3_trigger_unit;

  localparam int N = 5;

  localparam logic [11:0] TSEL  = 12'h7a0;
  localparam logic [11:0] TD1   = 12'h7a1;
  localparam logic [11:0] TD2   = 12'h7a2;
  localparam logic [11:0] TINFO = 12'h7a4;

  logic        clk;
  logic        rst;
  logic [11:0] cfg_addr;
  logic        cfg_wen;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        trig_m_en;
  logic        m_mode;
  logic        d_mode;
  logic        pc_vld;
  logic [31:0] pc;
  logic        dmem_vld;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic        break_req;
  logic        break_d_mode;
  logic [3:0]  break_idx;
  logic        break_ack;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  hazard3_trigger_unit #(
    .N_TRIGGERS(N), .W_DATA(32), .W_ADDR(32), .CHAIN_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_addr(cfg_addr), .cfg_wen(cfg_wen), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .trig_m_en(trig_m_en), .m_mode(m_mode), .d_mode(d_mode),
    .pc_vld(pc_vld), .pc(pc),
    .dmem_vld(dmem_vld), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .break_req(break_req), .break_d_mode(break_d_mode),
    .break_idx(break_idx), .break_ack(break_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected tdata1 read value.
  function automatic logic [31:0] t1(input logic dm, input logic act,
                                     input logic ch, input logic [3:0] mt,
                                     input logic m, input logic u,
                                     input logic ex, input logic st,
                                     input logic ld, input logic hit = 1'b0);
    return {4'h2, dm, 6'd31, hit, 4'b0000, 3'b000, act, ch, mt,
            m, 2'b00, u, ex, st, ld};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wen   = 1'b1;
    step(1);
    cfg_wen   = 1'b0;
  endtask

  task automatic csr_rd(input string name, input logic [11:0] a,
                        input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check(name, cfg_rdata, exp);
    step(1);
  endtask

  task automatic drive(input logic pv, input logic [31:0] p, input logic dv,
                       input logic dw, input logic [31:0] da);
    pc_vld     = pv;
    pc         = p;
    dmem_vld   = dv;
    dmem_write = dw;
    dmem_addr  = da;
    step(1);
    pc_vld     = 1'b0;
    dmem_vld   = 1'b0;
  endtask

  task automatic ack();
    break_ack = 1'b1;
    step(1);
    break_ack = 1'b0;
  endtask

  // Monitor: a new break is presented when break_req is high and either it
  // was low last cycle or an ack was applied at the loading edge.
  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic [4:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (break_req && (!prev_req || prev_ack)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_break: got %h expected none",
                   {break_d_mode, break_idx});
        end else begin
          check("break_out", 32'({break_d_mode, break_idx}),
                32'(exp_q.pop_front()));
        end
      end else if (break_req && prev_req && !prev_ack) begin
        check("break_hold", 32'({break_d_mode, break_idx}), 32'(prev_out));
      end
      prev_req = break_req;
      prev_ack = break_ack;
      prev_out = {break_d_mode, break_idx};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_addr = TSEL; cfg_wen = 1'b0; cfg_wdata = '0;
    trig_m_en = 1'b1; m_mode = 1'b1; d_mode = 1'b0;
    pc_vld = 1'b0; pc = '0; dmem_vld = 1'b0; dmem_write = 1'b0;
    dmem_addr = '0; break_ack = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset state
    check("rst_break_req", 32'(break_req), 0);
    check("rst_break_out", 32'({break_d_mode, break_idx}), 0);
    csr_rd("rst_tselect", TSEL, 0);
    csr_rd("rst_tdata1", TD1, 32'h23e0_0000);
    csr_rd("rst_tdata2", TD2, 0);
    csr_rd("rst_tinfo", TINFO, 4);

    // T0: execute, equal 0x100
    csr_wr(TD2, 32'h100);
    csr_wr(TD1, t1(0, 0, 0, 0, 1, 0, 1, 0, 0));
    m_mode = 1'b0;
    drive(1, 32'h100, 0, 0, 0);
    check("t0_umode_nofire", 32'(break_req), 0);
    m_mode = 1'b1;
    drive(0, 32'h100, 0, 0, 0);
    check("t0_pcvld_nofire", 32'(break_req), 0);
    exp_q.push_back({1'b0, 4'd0});
    drive(1, 32'h100, 0, 0, 0);
    check("t0_latency", 32'(break_req), 1);
    csr_rd("t0_hit_set", TD1, t1(0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    ack();
    check("t0_ack_clear", 32'(break_req), 0);
    csr_wr(TD1, t1(0, 0, 0, 0, 1, 0, 1, 0, 0));
    csr_rd("t0_hit_clear", TD1, t1(0, 0, 0, 0, 1, 0, 1, 0, 0));
    csr_wr(TD1, 0);

    // T1: store, NAPOT 0x2007 covers 0x2000..0x200f
    csr_wr(TSEL, 1);
    csr_wr(TD2, 32'h2007);
    csr_wr(TD1, t1(0, 0, 0, 1, 1, 0, 0, 1, 0));
    exp_q.push_back({1'b0, 4'd1});
    drive(0, 0, 1, 1, 32'h200c);
    check("t1_napot_fire", 32'(break_req), 1);
    ack();
    drive(0, 0, 1, 1, 32'h2010);
    check("t1_napot_above", 32'(break_req), 0);
    drive(0, 0, 1, 0, 32'h2004);
    check("t1_load_ignored", 32'(break_req), 0);
    exp_q.push_back({1'b0, 4'd1});
    drive(0, 0, 1, 1, 32'h2000);
    check("t1_napot_base", 32'(break_req), 1);
    ack();
    csr_wr(TD1, 0);

    // Chain: T0 load >= 0x1000 (chained) with T1 load < 0x2000
    csr_wr(TSEL, 0);
    csr_wr(TD2, 32'h1000);
    csr_wr(TD1, t1(0, 0, 1, 2, 1, 0, 0, 0, 1));
    csr_rd("chain_rdback", TD1, t1(0, 0, 1, 2, 1, 0, 0, 0, 1));
    csr_wr(TSEL, 1);
    csr_wr(TD2, 32'h2000);
    csr_wr(TD1, t1(0, 0, 0, 3, 1, 0, 0, 0, 1));
    drive(0, 0, 1, 0, 32'h2800);
    check("chain_t0_only", 32'(break_req), 0);
    drive(0, 0, 1, 0, 32'h0800);
    check("chain_t1_only", 32'(break_req), 0);
    csr_rd("chain_t1_nohit", TD1, t1(0, 0, 0, 3, 1, 0, 0, 0, 1));
    csr_wr(TSEL, 0);
    csr_rd("chain_t0_nohit", TD1, t1(0, 0, 1, 2, 1, 0, 0, 0, 1));
    exp_q.push_back({1'b0, 4'd1});
    drive(0, 0, 1, 0, 32'h1800);
    check("chain_fire", 32'(break_req), 1);
    ack();
    csr_wr(TD1, 0);
    csr_wr(TSEL, 1);
    csr_rd("chain_t1_hit", TD1, t1(0, 0, 0, 3, 1, 0, 0, 0, 1, 1));
    csr_wr(TD1, 0);
    csr_wr(TSEL, N - 1);
    csr_wr(TD1, t1(0, 0, 1, 0, 1, 0, 0, 0, 1));
    csr_rd("chain_last_zero", TD1, t1(0, 0, 0, 0, 1, 0, 0, 0, 1));
    csr_wr(TD1, 0);

    // T2: D-mode-only trigger, locked outside D-mode
    d_mode = 1'b1;
    csr_wr(TSEL, 2);
    csr_wr(TD1, t1(1, 1, 0, 0, 1, 0, 1, 0, 0));
    csr_wr(TD2, 32'h300);
    drive(1, 32'h300, 0, 0, 0);
    check("t2_dmode_suppress", 32'(break_req), 0);
    d_mode = 1'b0;
    csr_wr(TD1, 0);
    csr_wr(TD2, 0);
    csr_rd("t2_td1_locked", TD1, t1(1, 1, 0, 0, 1, 0, 1, 0, 0));
    csr_rd("t2_td2_locked", TD2, 32'h300);
    trig_m_en = 1'b0;
    exp_q.push_back({1'b1, 4'd2});
    drive(1, 32'h300, 0, 0, 0);
    check("t2_fire_dmode", 32'({break_req, break_d_mode}), 32'b11);
    ack();
    trig_m_en = 1'b1;

    // T0 (M) and T3 (D) together, drop while pending, ack+fire
    csr_wr(TSEL, 0);
    csr_wr(TD2, 32'h400);
    csr_wr(TD1, t1(0, 0, 0, 0, 1, 0, 1, 0, 0));
    csr_wr(TSEL, 1);
    csr_wr(TD2, 32'h600);
    csr_wr(TD1, t1(0, 0, 0, 0, 1, 0, 0, 0, 1));
    d_mode = 1'b1;
    csr_wr(TSEL, 3);
    csr_wr(TD1, t1(1, 1, 0, 0, 1, 0, 1, 0, 0));
    csr_wr(TD2, 32'h400);
    d_mode = 1'b0;
    exp_q.push_back({1'b1, 4'd3});
    drive(1, 32'h400, 0, 0, 0);
    check("dual_prio", 32'({break_req, break_d_mode, break_idx}),
          32'({1'b1, 1'b1, 4'd3}));
    drive(0, 0, 1, 0, 32'h600);
    check("drop_held", 32'({break_req, break_d_mode, break_idx}),
          32'({1'b1, 1'b1, 4'd3}));
    csr_wr(TSEL, 1);
    csr_rd("drop_nohit", TD1, t1(0, 0, 0, 0, 1, 0, 0, 0, 1));
    break_ack = 1'b1;
    exp_q.push_back({1'b0, 4'd1});
    drive(0, 0, 1, 0, 32'h600);
    break_ack = 1'b0;
    check("ack_fire_reload", 32'({break_req, break_d_mode, break_idx}),
          32'({1'b1, 1'b0, 4'd1}));
    ack();
    check("ack_final_clear", 32'(break_req), 0);

    // Out-of-range tselect
    csr_wr(TSEL, N);
    csr_rd("bad_sel_tselect", TSEL, N);
    csr_rd("bad_sel_tdata1", TD1, 0);
    csr_rd("bad_sel_tdata2", TD2, 0);
    csr_rd("bad_sel_tinfo", TINFO, 1);

    // Asynchronous reset while a break is pending
    exp_q.push_back({1'b1, 4'd3});
    drive(1, 32'h400, 0, 0, 0);
    check("pre_rst_req", 32'(break_req), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_drop", 32'(break_req), 0);
    step(1);
    rst = 1'b0;
    csr_rd("post_rst_tselect", TSEL, 0);
    csr_rd("post_rst_tdata1", TD1, 32'h23e0_0000);
    csr_rd("post_rst_tdata2", TD2, 0);

    step(3);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
